// File: rtl/pcw_mouse_port_if.sv
// pcw_mouse_port_if: groups the packet stream, I/O decode and read-data signals of the mouse port.
// Latency: none, wires only.
// Backpressure: none; the master drives packets and reads, the slave returns dout.
interface pcw_mouse_port_if;
  logic [1:0] mode;
  logic       mouse_strobe;
  logic [8:0] mouse_x;
  logic [8:0] mouse_y;
  logic [2:0] mouse_btn;
  logic       sel;
  logic [1:0] addr;
  logic [7:0] dout;

  modport master (
    output mode, mouse_strobe, mouse_x, mouse_y, mouse_btn, sel, addr,
    input  dout
  );

  modport slave (
    input  mode, mouse_strobe, mouse_x, mouse_y, mouse_btn, sel, addr,
    output dout
  );
endinterface

// File: rtl/pcw_mouse_port.sv
// pcw_mouse_port: integrates PS/2 packet deltas into scaled fixed-point accumulators, read as AMX nibbles or Kempston counters.
// Latency: packet to accumulator 1 clk_sys; sel rise to valid dout 1 clk_sys (first sel cycle shows previous data).
// Backpressure: none; every packet is absorbed (AMX saturates, Kempston wraps) and reads never stall.
module pcw_mouse_port #(
  parameter int CNT_W    = 8,
  parameter int SCALE_SH = 3,
  parameter int AMX_MAX  = 15
) (
  input  logic            clk_sys,
  input  logic            reset,
  pcw_mouse_port_if.slave mp
);

  // Accumulator width and a working width wide enough that acc + delta - consume never overflows
  localparam int ACC_W = CNT_W + SCALE_SH;
  localparam int WIDE  = ((ACC_W > 9) ? ACC_W : 9) + 2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [WIDE-1:0]  wide_t;

  localparam wide_t ACC_MAX = wide_t'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam wide_t ACC_MIN = -ACC_MAX - wide_t'(1);
  localparam wide_t R_MAX   = wide_t'(AMX_MAX);
  localparam wide_t R_MIN   = -R_MAX;

  localparam logic [1:0] MODE_AMX  = 2'b00;
  localparam logic [1:0] MODE_KEMP = 2'b01;
  localparam logic [1:0] ADDR_0    = 2'b00;
  localparam logic [1:0] ADDR_1    = 2'b01;
  localparam logic [1:0] ADDR_BTN  = 2'b10;

  // AMX reports at most AMX_MAX counts per read; the excess stays in the accumulator
  function automatic wide_t clamp_r(input wide_t v);
    if (v > R_MAX) return R_MAX;
    if (v < R_MIN) return R_MIN;
    return v;
  endfunction

  // Positive movement goes in the low nibble, negative magnitude in the high nibble
  function automatic logic [7:0] amx_byte(input wide_t r);
    logic [3:0] mag;
    mag = 4'((r < 0) ? -r : r);
    return (r < 0) ? {mag, 4'h0} : {4'h0, mag};
  endfunction

  // One accumulator update: add the packet delta, remove what a read consumed,
  // then saturate once on the combined result (AMX) or simply wrap (Kempston)
  function automatic acc_t acc_step(input acc_t       acc,
                                    input logic       add,
                                    input logic [8:0] delta,
                                    input logic       sub,
                                    input wide_t      r,
                                    input logic       sat);
    wide_t sum;
    sum = wide_t'(acc);
    if (add) sum = sum + wide_t'(signed'(delta));
    if (sub) sum = sum - (r <<< SCALE_SH);
    if (sat) begin
      if (sum > ACC_MAX)      sum = ACC_MAX;
      else if (sum < ACC_MIN) sum = ACC_MIN;
    end
    return acc_t'(sum);
  endfunction

  logic       strobe_q;
  logic       armed_q;
  logic       sel_q;
  logic [1:0] mode_q;
  acc_t       acc_x_q, acc_x_d;
  acc_t       acc_y_q, acc_y_d;
  logic [2:0] latch_q, latch_d;
  logic [7:0] data_q, data_d;

  logic       ev;
  logic       mode_chg;
  logic       is_amx;
  logic       is_kemp;
  logic       live;
  logic       take_ev;
  logic       rd;
  logic       cons_x;
  logic       cons_y;
  logic       btn_rd;
  logic [2:0] ev_btn;
  wide_t      int_x, int_y;
  wide_t      r_x, r_y;
  logic [7:0] btn_byte;

  // A strobe edge only counts once armed, so a level left over from before reset is ignored
  assign ev       = armed_q & (mp.mouse_strobe != strobe_q);
  assign mode_chg = (mp.mode != mode_q);
  assign is_amx   = (mp.mode == MODE_AMX);
  assign is_kemp  = (mp.mode == MODE_KEMP);
  assign live     = is_amx | is_kemp;
  assign take_ev  = ev & ~mode_chg & live;
  assign ev_btn   = take_ev ? mp.mouse_btn : 3'b000;
  assign rd       = mp.sel & ~sel_q;

  // Integer parts and AMX report values are always taken from the pre-event accumulators
  assign int_x = wide_t'(acc_x_q) >>> SCALE_SH;
  assign int_y = wide_t'(acc_y_q) >>> SCALE_SH;
  assign r_x   = clamp_r(int_x);
  assign r_y   = clamp_r(int_y);

  assign cons_x = rd & is_amx & (mp.addr == ADDR_1);
  assign cons_y = rd & is_amx & (mp.addr == ADDR_0);
  assign btn_rd = rd & live & (mp.addr == ADDR_BTN);

  // Active-low buttons: current level OR'd with the latched presses, ordered {right, middle, left}
  assign btn_byte = {5'b11111,
                     ~(mp.mouse_btn[1] | latch_q[1]),
                     ~(mp.mouse_btn[2] | latch_q[2]),
                     ~(mp.mouse_btn[0] | latch_q[0])};

  // Read data captured on the sel rising edge, held until the next read
  always_comb begin
    data_d = data_q;
    if (rd) begin
      data_d = 8'hFF;
      if (live) begin
        unique case (mp.addr)
          ADDR_0:   data_d = is_amx ? amx_byte(r_y) : int_x[7:0];
          ADDR_1:   data_d = is_amx ? amx_byte(r_x) : int_y[7:0];
          ADDR_BTN: data_d = btn_byte;
          default:  data_d = 8'hFF;
        endcase
      end
    end
  end

  // Accumulator and button-latch next state; a mode change wipes everything and drops the packet
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    latch_d = latch_q;
    if (mode_chg) begin
      acc_x_d = '0;
      acc_y_d = '0;
      latch_d = 3'b000;
    end else begin
      acc_x_d = acc_step(acc_x_q, take_ev, mp.mouse_x, cons_x, r_x, is_amx);
      acc_y_d = acc_step(acc_y_q, take_ev, mp.mouse_y, cons_y, r_y, is_amx);
      if (btn_rd) latch_d = ev_btn;
      else        latch_d = latch_q | ev_btn;
    end
  end

  // State registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
      sel_q    <= 1'b0;
      mode_q   <= MODE_AMX;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      latch_q  <= 3'b000;
      data_q   <= 8'hFF;
    end else begin
      strobe_q <= mp.mouse_strobe;
      armed_q  <= 1'b1;
      sel_q    <= mp.sel;
      mode_q   <= mp.mode;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      latch_q  <= latch_d;
      data_q   <= data_d;
    end
  end

  assign mp.dout = mp.sel ? data_q : 8'hFF;

endmodule

// File: tb/tb_pcw_mouse_port.sv
// tb_pcw_mouse_port: two ports (SCALE_SH 3 and 0) on shared stimulus, checked every cycle against a behavioural model.
// Latency: inputs change 2 time units after posedge, outputs sampled at negedge.
// Backpressure: not applicable.
module tb_pcw_mouse_port;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pcw_mouse_port_if ifa ();
  pcw_mouse_port_if ifb ();

  assign ifb.mode         = ifa.mode;
  assign ifb.mouse_strobe = ifa.mouse_strobe;
  assign ifb.mouse_x      = ifa.mouse_x;
  assign ifb.mouse_y      = ifa.mouse_y;
  assign ifb.mouse_btn    = ifa.mouse_btn;
  assign ifb.sel          = ifa.sel;
  assign ifb.addr         = ifa.addr;

  pcw_mouse_port #(.CNT_W(8), .SCALE_SH(3), .AMX_MAX(15)) dut0 (
    .clk_sys (clk),
    .reset   (reset),
    .mp      (ifa)
  );

  pcw_mouse_port #(.CNT_W(8), .SCALE_SH(0), .AMX_MAX(15)) dut1 (
    .clk_sys (clk),
    .reset   (reset),
    .mp      (ifb)
  );

  // ---------------- behavioural model (integer arithmetic) ----------------
  int         m_acc [2][2];   // [dut][0=x,1=y], fixed-point value as a plain integer
  logic [7:0] m_data [2];
  logic [2:0] m_latch [2];
  logic       m_strobe, m_armed, m_sel;
  logic [1:0] m_mode;

  function automatic int floor_div(input int v, input int d);
    return (v >= 0) ? (v / d) : -((-v + d - 1) / d);
  endfunction

  function automatic int clampi(input int v);
    if (v > 15)  return 15;
    if (v < -15) return -15;
    return v;
  endfunction

  function automatic int satn(input int v, input int n);
    int lim;
    lim = 1 << (n - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
  endfunction

  function automatic int wrapn(input int v, input int n);
    int m, t;
    m = 1 << n;
    t = ((v % m) + m) % m;
    if (t >= m / 2) t = t - m;
    return t;
  endfunction

  function automatic logic [7:0] amx_byte(input int r);
    return (r >= 0) ? {4'h0, 4'(r)} : {4'(-r), 4'h0};
  endfunction

  task automatic model_step();
    logic       ev, mchg, rd, take;
    int         sh, n, ix, iy, rx, ry, subx, suby, dx, dy, nx, ny;
    logic [7:0] dat, bb;
    logic [2:0] evb, l;
    ev   = m_armed && (ifa.mouse_strobe != m_strobe);
    mchg = (ifa.mode != m_mode);
    rd   = ifa.sel && !m_sel;
    take = ev && !mchg && (ifa.mode < 2'd2);
    dx   = int'($signed(ifa.mouse_x));
    dy   = int'($signed(ifa.mouse_y));
    evb  = take ? ifa.mouse_btn : 3'b000;
    for (int k = 0; k < 2; k++) begin
      sh   = (k == 0) ? 3 : 0;
      n    = 8 + sh;
      ix   = floor_div(m_acc[k][0], 1 << sh);
      iy   = floor_div(m_acc[k][1], 1 << sh);
      rx   = clampi(ix);
      ry   = clampi(iy);
      subx = 0;
      suby = 0;
      l    = m_latch[k];
      bb   = {5'b11111, ~(ifa.mouse_btn[1] | l[1]), ~(ifa.mouse_btn[2] | l[2]), ~(ifa.mouse_btn[0] | l[0])};
      dat  = m_data[k];
      if (rd) begin
        dat = 8'hFF;
        if (ifa.mode == 2'b00) begin
          if (ifa.addr == 2'd0) begin dat = amx_byte(ry); suby = ry * (1 << sh); end
          else if (ifa.addr == 2'd1) begin dat = amx_byte(rx); subx = rx * (1 << sh); end
          else if (ifa.addr == 2'd2) dat = bb;
        end else if (ifa.mode == 2'b01) begin
          if (ifa.addr == 2'd0)      dat = 8'(ix);
          else if (ifa.addr == 2'd1) dat = 8'(iy);
          else if (ifa.addr == 2'd2) dat = bb;
        end
      end
      nx = m_acc[k][0] + (take ? dx : 0) - subx;
      ny = m_acc[k][1] + (take ? dy : 0) - suby;
      if (mchg) begin
        m_acc[k][0] = 0;
        m_acc[k][1] = 0;
        m_latch[k]  = 3'b000;
      end else begin
        if (ifa.mode == 2'b00) begin
          m_acc[k][0] = satn(nx, n);
          m_acc[k][1] = satn(ny, n);
        end else if (ifa.mode == 2'b01) begin
          m_acc[k][0] = wrapn(nx, n);
          m_acc[k][1] = wrapn(ny, n);
        end
        if (rd && ifa.mode < 2'd2 && ifa.addr == 2'd2) m_latch[k] = evb;
        else                                         m_latch[k] = l | evb;
      end
      m_data[k] = dat;
    end
    m_strobe = ifa.mouse_strobe;
    m_armed  = 1'b1;
    m_mode   = ifa.mode;
    m_sel    = ifa.sel;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k][0] = 0;
        m_acc[k][1] = 0;
        m_latch[k]  = 3'b000;
        m_data[k]   = 8'hFF;
      end
      m_strobe = 1'b0;
      m_armed  = 1'b0;
      m_mode   = 2'b00;
      m_sel    = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [7:0] cmp_exp, cmp_got;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cmp_exp = ifa.sel ? m_data[k] : 8'hFF;
      cmp_got = (k == 0) ? ifa.dout : ifb.dout;
      n_tests++;
      if (cmp_got !== cmp_exp) begin
        n_fail++;
        $display("FAIL cycle_dout dut%0d t=%0t got=%h expected=%h", k, $time, cmp_got, cmp_exp);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Present packet fields and toggle the strobe without advancing time
  task automatic arm_ev(input int x, input int y, input logic [2:0] b);
    ifa.mouse_x      = 9'(x);
    ifa.mouse_y      = 9'(y);
    ifa.mouse_btn    = b;
    ifa.mouse_strobe = ~ifa.mouse_strobe;
  endtask

  task automatic send_ev(input int x, input int y, input logic [2:0] b);
    arm_ev(x, y, b);
    @(posedge clk); #2;
  endtask

  // Two-cycle sel pulse; data checked on both ports in the cycle after the rise
  task automatic rd(input logic [1:0] a, input logic [7:0] e0, input logic [7:0] e1, input string nm);
    ifa.addr = a;
    ifa.sel  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_d0"}, ifa.dout, e0);
    chk({nm, "_d1"}, ifb.dout, e1);
    @(posedge clk); #2;
    ifa.sel = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    ifa.mode         = 2'b00;
    ifa.mouse_strobe = 1'b0;
    ifa.mouse_x      = 9'd0;
    ifa.mouse_y      = 9'd0;
    ifa.mouse_btn    = 3'b000;
    ifa.sel          = 1'b0;
    ifa.addr         = 2'b00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;

    // Reset state: idle bus reads FF, first sel cycle shows reset data FF, empty accumulator reads 00
    @(negedge clk);
    chk("rst_idle_d0", ifa.dout, 8'hFF);
    chk("rst_idle_d1", ifb.dout, 8'hFF);
    @(posedge clk); #2;
    ifa.addr = 2'b01;
    ifa.sel  = 1'b1;
    @(negedge clk);
    chk("rst_data_d0", ifa.dout, 8'hFF);
    chk("rst_data_d1", ifb.dout, 8'hFF);
    @(posedge clk); #2;
    ifa.sel = 1'b0;
    @(posedge clk); #2;
    rd(2'b01, 8'h00, 8'h00, "rst_acc");

    // AMX fractional residue
    send_ev(20, 0, 3'b000);
    rd(2'b01, 8'h02, 8'h0F, "amx_x20");
    send_ev(4, 0, 3'b000);
    rd(2'b01, 8'h01, 8'h09, "amx_x4");
    rd(2'b01, 8'h00, 8'h00, "amx_x_empty");

    // AMX negative Y
    send_ev(0, -40, 3'b000);
    rd(2'b00, 8'h50, 8'hF0, "amx_y_neg1");
    rd(2'b00, 8'h00, 8'hF0, "amx_y_neg2");

    // AMX saturation then drain
    for (int i = 0; i < 10; i++) send_ev(255, 0, 3'b000);
    for (int i = 0; i < 8; i++) rd(2'b01, 8'h0F, 8'h0F, "amx_sat");
    rd(2'b01, 8'h07, 8'h07, "amx_sat_tail");
    rd(2'b01, 8'h00, 8'h00, "amx_sat_empty");

    // Button latch, and a press arriving on the same edge as a button read
    send_ev(0, 0, 3'b001);
    send_ev(0, 0, 3'b000);
    rd(2'b10, 8'hFE, 8'hFE, "btn_latched");
    rd(2'b10, 8'hFF, 8'hFF, "btn_cleared");
    arm_ev(0, 0, 3'b010);
    rd(2'b10, 8'hFB, 8'hFB, "btn_coinc");
    ifa.mouse_btn = 3'b000;
    rd(2'b10, 8'hFB, 8'hFB, "btn_coinc_kept");
    rd(2'b10, 8'hFF, 8'hFF, "btn_coinc_clr");

    // Event and consuming read on the same edge
    send_ev(24, 0, 3'b000);
    arm_ev(16, 0, 3'b000);
    rd(2'b01, 8'h03, 8'h0F, "coinc_x");
    rd(2'b01, 8'h02, 8'h0F, "coinc_after");
    rd(2'b01, 8'h00, 8'h0A, "coinc_rest");

    // Kempston: wrapping, non-consuming
    ifa.mode = 2'b01;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) send_ev(255, 0, 3'b000);
    rd(2'b00, 8'h5F, 8'hFD, "kemp_x1");
    rd(2'b00, 8'h5F, 8'hFD, "kemp_x2");
    send_ev(0, -1, 3'b000);
    rd(2'b01, 8'hFF, 8'hFF, "kemp_y");

    // Mode change discards a coincident event
    arm_ev(100, 0, 3'b000);
    ifa.mode = 2'b00;
    @(posedge clk); #2;
    rd(2'b01, 8'h00, 8'h00, "mode_chg_drop");

    // Reset in the middle of a read, with a strobe toggle while in reset
    send_ev(16, 0, 3'b000);
    ifa.addr = 2'b01;
    ifa.sel  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midread_d0", ifa.dout, 8'h02);
    chk("midread_d1", ifb.dout, 8'h0F);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_midread_d0", ifa.dout, 8'hFF);
    chk("rst_midread_d1", ifb.dout, 8'hFF);
    ifa.mouse_x      = 9'd40;
    ifa.mouse_strobe = 1'b1;
    ifa.sel          = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    rd(2'b01, 8'h00, 8'h00, "post_rst_noev");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcw_mouse_port.md
# pcw_mouse_port

Parametrised multi-protocol mouse port for the PCW core, sitting between the HPS PS/2 mouse packet stream and the Z80 I/O decode. Each strobed packet's X/Y deltas are integrated into scaled, saturating fixed-point accumulators that keep their fractional residue. The accumulators are presented as either AMX sign-magnitude nibbles (read-and-consume) or Kempston-style wrapping absolute counters. Button presses are latched so that a click shorter than the CPU polling interval is still reported once.

## Interface
- CNT_W, default 8: signed integer width of each position accumulator (4..16).
- SCALE_SH, default 3: right-shift applied to incoming deltas; the low SCALE_SH bits are kept as a fractional residue.
- AMX_MAX, default 15: maximum magnitude returned per AMX read (1..15).

Ports:
- clk_sys, in, 1: system clock, same as HPS_IO clk_sys.
- reset, in, 1: asynchronous, active-high reset.
- mode, in, 2: 00 = AMX, 01 = Kempston, 10/11 = disabled (all reads return 8'hFF).
- mouse_strobe, in, 1: toggles once per new packet.
- mouse_x, in, 9: signed two's-complement X delta, right positive.
- mouse_y, in, 9: signed two's-complement Y delta, up positive.
- mouse_btn, in, 3: {middle, right, left}, 1 = pressed.
- sel, in, 1: port select from the I/O decode.
- addr, in, 2: register address.
- dout, out, 8: read data; equals data when sel = 1, else 8'hFF.

## Operation
- Packet event: strobe_d is registered from mouse_strobe. An event is mouse_strobe != strobe_d while the armed flag is 1.
  - armed resets to 0 and sets on the first clock after reset, so a strobe level left over from before reset produces no event.
- Accumulators: acc_x and acc_y are each CNT_W+SCALE_SH bits, signed fixed-point.
  - On an event, acc += sign-extended delta.
  - Integer part: int = acc >>> SCALE_SH (arithmetic shift).
- AMX mode:
  - Accumulation saturates at the signed limits of CNT_W+SCALE_SH bits.
  - Reported value: r = int clamped to [-AMX_MAX, +AMX_MAX].
  - Data byte: r >= 0 gives {4'h0, |r|}; r < 0 gives {|r|, 4'h0}.
  - addr 00 reads Y, addr 01 reads X.
  - A read consumes: acc -= r << SCALE_SH, so the fractional bits and any excess beyond the clamp are retained.
- Kempston mode:
  - Accumulation wraps modulo 2^(CNT_W+SCALE_SH); no saturation; reads do not consume.
  - addr 00 returns X int[7:0], addr 01 returns Y int[7:0]. When CNT_W < 8, int is sign-extended to 8 bits.
- Buttons:
  - latch[2:0] sets per bit on any event where that mouse_btn bit = 1.
  - addr 10 returns {5'b11111, ~(right|latch_r), ~(middle|latch_m), ~(left|latch_l)}, with button levels sampled at the sel rise.
  - Reading addr 10 clears latch, in both modes.
- addr 11 returns 8'hFF.
- Mode change: any cycle where mode differs from its registered copy clears both accumulators and latch. An event arriving in that same cycle is discarded.
- Simultaneous event and consuming read in one cycle: acc_next = sat(acc + delta - (r << SCALE_SH)).
  - r is computed from the pre-event acc.
  - Saturation is applied once, to the final sum.
- Simultaneous event and addr 10 read: latch_next = the event's mouse_btn (the new press is not lost).

## Timing
- Reset values:
  - data = 8'hFF; dout = 8'hFF whenever sel = 0.
  - acc_x, acc_y, latch = 0; strobe_d = 0; armed = 0; mode copy = 00.
- A read is triggered by the rising edge of sel sampled on clk_sys (old_sel = 0, sel = 1).
  - data is updated at that edge and is valid on dout from the following cycle.
  - sel must stay high for at least 2 clk_sys cycles. During the first cycle dout shows the previous data.
- Consumption and latch clear take effect in the same edge that captures data.
- Event-to-accumulator latency is 1 cycle. A read whose sel rise lands in that edge sees the pre-event value, as defined above.
- Reset asserted mid-read: data returns to 8'hFF immediately and nothing is consumed.

## Test plan
- AMX, SCALE_SH = 3: one event with x = +20, then read addr 01 -> 8'h02, residue 4. Event x = +4, then read addr 01 -> 8'h01. A further read -> 8'h00.
- AMX: event with y = -40, then read addr 00 -> 8'h50. A second read -> 8'h00.
- AMX, CNT_W = 8: ten events with x = +255 saturate the integer part at 127. Successive reads return 8'h0F eight times, then 8'h07, then 8'h00.
- Kempston, SCALE_SH = 0: three events with x = +255, then read addr 00 -> 8'hFD. Repeated reads -> 8'hFD (no consume).
- Event with left pressed, then event with all released, then read addr 10 -> 8'hFE. Next read -> 8'hFF.
- Strobe toggled in the same cycle as a sel rise on addr 01, with acc int = 3 and x = +16 (SCALE_SH = 3): data = 8'h03, final int = 2. Also toggle strobe during reset and check the first post-reset cycle produces no event.
